// File: rtl/lsu_writeback_pkg.sv
// Shared encodings for the LSU writeback stage: wb_sel mux codes, memory
// opcodes, funct3 access codes, FSM states and the registered bus request
// bundle.
package lsu_writeback_pkg;

    localparam logic [1:0] WB_PC4 = 2'b00;
    localparam logic [1:0] WB_ALU = 2'b01;
    localparam logic [1:0] WB_MEM = 2'b10;
    localparam logic [1:0] WB_CSR = 2'b11;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } lsu_state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } acc_size_t;

    // Registered bus request, held stable for the whole BUSY phase.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        we;
    } bus_req_t;

    // Access size comes from the low funct3 bits; the unused 011/110/111
    // codes fall into the word bucket.
    function automatic acc_size_t f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return SZ_BYTE;
            2'b01:   return SZ_HALF;
            default: return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_writeback_load_extract.sv
// Purpose: pick and sign/zero-extend the loaded byte/half/word from a bus word.
// Latency: purely combinational.
// Backpressure: none; no handshake.
import lsu_writeback_pkg::*;

module load_extract (
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Lane select by offset, then extension by funct3 (unknown codes read as LW).
    always_comb begin
        case (offset)
            2'd0:    byte_sel = rdata[7:0];
            2'd1:    byte_sel = rdata[15:8];
            2'd2:    byte_sel = rdata[23:16];
            default: byte_sel = rdata[31:24];
        endcase
        half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            F3_LB:   value = {{24{byte_sel[7]}}, byte_sel};
            F3_LBU:  value = {24'd0, byte_sel};
            F3_LH:   value = {{16{half_sel[15]}}, half_sel};
            F3_LHU:  value = {16'd0, half_sel};
            default: value = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_writeback.sv
// Purpose: MEM/WB stage - register-file writeback plus a single-outstanding data-bus FSM (LSU_MISALIGN_TRAP_EN enables misalignment trap).
// Latency: non-memory ops write back same cycle; loads/stores take request + wait + ack + 1 DONE cycle (min 3).
// Backpressure: Stall_MW holds the stage register from request issue until the ack; bus stalls beyond TIMEOUT abort with bus_err.
import lsu_writeback_pkg::*;

module lsu_writeback #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_wrMW,
    input  logic [1:0]  wb_selMW,
    input  logic        csr_reg_rdMW,
    input  logic [2:0]  InstF_MW_funct3,
    input  logic [6:0]  InstF_MW_opcode,
    input  logic [4:0]  rdMW,
    input  logic [31:0] AluResultMW,
    input  logic [31:0] WriteDataMW,
    input  logic [31:0] PCMW,
    input  logic [31:0] CsrRdataMW,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [31:0] dbus_wdata,
    output logic [3:0]  dbus_be,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic        Stall_MW,
    output logic        misalign_exc,
    output logic        bus_err
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    lsu_state_t  state;
    logic [7:0]  wait_cnt;
    bus_req_t    req_q;
    logic        req_vld;
    logic [2:0]  f3_q;
    logic [1:0]  off_q;
    logic [4:0]  rd_q;
    logic        load_q;
    logic [31:0] rdata_q;
    logic        bus_err_q;

    logic        is_load;
    logic        is_store;
    logic        is_mem;
    logic        misaligned;
    logic        start;
    logic        in_idle;
    logic        in_busy;
    logic        in_done;
    acc_size_t   size;
    logic [1:0]  offset;
    logic [3:0]  be_n;
    logic [31:0] wdata_n;
    logic [31:0] load_val;
    logic        we_raw;

    // The CSR value arrives already selected through wb_selMW; the read flag
    // only matters upstream.
    logic unused_csr_rd;
    assign unused_csr_rd = csr_reg_rdMW;

    // While rst is low the combinational outputs behave as in IDLE.
    assign in_idle = !rst || (state == ST_IDLE);
    assign in_busy = rst && (state == ST_BUSY);
    assign in_done = rst && (state == ST_DONE);

    // Decode access type, size, lane offset, byte enables and lane-replicated store data.
    always_comb begin
        is_load  = (InstF_MW_opcode == OP_LOAD);
        is_store = (InstF_MW_opcode == OP_STORE);
        is_mem   = is_load || is_store;
        size     = f3_size(InstF_MW_funct3);
        case (size)
            SZ_BYTE: begin
                offset  = AluResultMW[1:0];
                be_n    = 4'b0001 << AluResultMW[1:0];
                wdata_n = {4{WriteDataMW[7:0]}};
            end
            SZ_HALF: begin
                offset  = {AluResultMW[1], 1'b0};
                be_n    = 4'b0011 << {AluResultMW[1], 1'b0};
                wdata_n = {2{WriteDataMW[15:0]}};
            end
            default: begin
                offset  = 2'b00;
                be_n    = 4'b1111;
                wdata_n = WriteDataMW;
            end
        endcase
    end

`ifdef LSU_MISALIGN_TRAP_EN
    assign misaligned = is_mem &&
                        (((size == SZ_HALF) && AluResultMW[0]) ||
                         ((size == SZ_WORD) && (AluResultMW[1:0] != 2'b00)));
`else
    assign misaligned = 1'b0;
`endif

    assign start = in_idle && is_mem && !misaligned;

    // Transaction FSM: capture the request in IDLE, wait for ack or timeout in BUSY, write back in DONE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= 8'd0;
            req_q     <= '0;
            req_vld   <= 1'b0;
            f3_q      <= 3'd0;
            off_q     <= 2'd0;
            rd_q      <= 5'd0;
            load_q    <= 1'b0;
            rdata_q   <= 32'd0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state       <= ST_BUSY;
                        wait_cnt    <= 8'd0;
                        req_vld     <= 1'b1;
                        req_q.addr  <= {AluResultMW[31:2], 2'b00};
                        req_q.wdata <= wdata_n;
                        req_q.be    <= be_n;
                        req_q.we    <= is_store;
                        f3_q        <= InstF_MW_funct3;
                        off_q       <= offset;
                        rd_q        <= rdMW;
                        load_q      <= is_load;
                    end
                end
                ST_BUSY: begin
                    if (dbus_ack) begin
                        rdata_q <= dbus_rdata;
                        req_vld <= 1'b0;
                        state   <= ST_DONE;
                    end else if (wait_cnt == TMO_LAST) begin
                        bus_err_q <= 1'b1;
                        req_vld   <= 1'b0;
                        wait_cnt  <= 8'd0;
                        state     <= ST_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state   <= ST_IDLE;
                    req_vld <= 1'b0;
                end
            endcase
        end
    end

    load_extract u_load_extract (
        .funct3 (f3_q),
        .offset (off_q),
        .rdata  (rdata_q),
        .value  (load_val)
    );

    assign dbus_req   = req_vld;
    assign dbus_we    = req_q.we;
    assign dbus_addr  = req_q.addr;
    assign dbus_wdata = req_q.wdata;
    assign dbus_be    = req_q.be;
    assign bus_err    = bus_err_q;

    // Writeback mux, write-enable qualification and stall/exception outputs.
    always_comb begin
        rf_waddr = in_done ? rd_q : rdMW;
        case (wb_selMW)
            WB_PC4:  rf_wdata = PCMW + 32'd4;
            WB_ALU:  rf_wdata = AluResultMW;
            WB_MEM:  rf_wdata = load_val;
            default: rf_wdata = CsrRdataMW;
        endcase
        we_raw = 1'b0;
        if (in_idle) begin
            we_raw = reg_wrMW && !is_mem;
        end else if (in_done) begin
            we_raw = reg_wrMW && load_q;
        end
        rf_we        = we_raw && rst && (rf_waddr != 5'd0);
        Stall_MW     = start || in_busy;
        misalign_exc = in_idle && rst && misaligned;
    end

endmodule

// File: tb/tb_lsu_writeback.sv
module tb_lsu_writeback;

    localparam int TO = 4;
    localparam int K_RFW  = 0;
    localparam int K_BUS  = 1;
    localparam int K_BERR = 2;
    localparam int K_MIS  = 3;
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;
    localparam logic [6:0] OPC_ALU   = 7'b0010011;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        reg_wrMW = 1'b0;
    logic [1:0]  wb_selMW = 2'b01;
    logic        csr_reg_rdMW = 1'b0;
    logic [2:0]  InstF_MW_funct3 = 3'd0;
    logic [6:0]  InstF_MW_opcode = OPC_ALU;
    logic [4:0]  rdMW = 5'd0;
    logic [31:0] AluResultMW = 32'd0;
    logic [31:0] WriteDataMW = 32'd0;
    logic [31:0] PCMW = 32'd0;
    logic [31:0] CsrRdataMW = 32'd0;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [31:0] dbus_wdata;
    logic [3:0]  dbus_be;
    logic        dbus_ack = 1'b0;
    logic [31:0] dbus_rdata = 32'd0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        Stall_MW;
    logic        misalign_exc;
    logic        bus_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
        logic        we;
    } exp_t;
    exp_t exp_q[$];

    lsu_writeback #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .reg_wrMW(reg_wrMW), .wb_selMW(wb_selMW), .csr_reg_rdMW(csr_reg_rdMW),
        .InstF_MW_funct3(InstF_MW_funct3), .InstF_MW_opcode(InstF_MW_opcode),
        .rdMW(rdMW), .AluResultMW(AluResultMW), .WriteDataMW(WriteDataMW),
        .PCMW(PCMW), .CsrRdataMW(CsrRdataMW),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_wdata(dbus_wdata), .dbus_be(dbus_be),
        .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .Stall_MW(Stall_MW), .misalign_exc(misalign_exc), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] be, input logic we);
        exp_t e;
        e.kind = k; e.a = a; e.d = d; e.be = be; e.we = we;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: pops one expectation per observed DUT event.
    task automatic check_evt(input int k, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be, input logic we);
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d a=%h d=%h be=%b we=%b, expected none",
                     k, a, d, be, we);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.a !== a || e.d !== d || e.be !== be || e.we !== we) begin
                bad++;
                $display("FAIL event: got kind=%0d a=%h d=%h be=%b we=%b, expected kind=%0d a=%h d=%h be=%b we=%b",
                         k, a, d, be, we, e.kind, e.a, e.d, e.be, e.we);
            end
        end
    endtask

    logic prev_req = 1'b0;
    always @(negedge clk) begin
        if (dbus_req && !prev_req)
            check_evt(K_BUS, dbus_addr, dbus_wdata, dbus_be, dbus_we);
        if (rf_we)
            check_evt(K_RFW, {27'd0, rf_waddr}, rf_wdata, 4'd0, 1'b0);
        if (bus_err)
            check_evt(K_BERR, 32'd0, 32'd0, 4'd0, 1'b0);
        if (misalign_exc)
            check_evt(K_MIS, 32'd0, 32'd0, 4'd0, dbus_req || Stall_MW || rf_we);
        prev_req <= dbus_req;
    end

    task automatic set_nop();
        InstF_MW_opcode = OPC_ALU;
        reg_wrMW = 1'b0;
        wb_selMW = 2'b01;
        rdMW = 5'd0;
    endtask

    // Non-memory op held for one cycle; checks stall and (if no write expected) rf_we.
    task automatic alu_op(input string name, input logic [1:0] sel, input logic rw,
                          input logic [4:0] rd, input logic [31:0] alu,
                          input logic [31:0] pc, input logic [31:0] csr,
                          input logic exp_we, input logic [31:0] exp_d);
        @(posedge clk); #1;
        InstF_MW_opcode = OPC_ALU; wb_selMW = sel; reg_wrMW = rw; rdMW = rd;
        AluResultMW = alu; PCMW = pc; CsrRdataMW = csr;
        if (exp_we) push(K_RFW, {27'd0, rd}, exp_d, 4'd0, 1'b0);
        @(negedge clk);
        chk({name, "_stall"}, {31'd0, Stall_MW}, 32'd0);
        if (!exp_we) chk({name, "_rf_we"}, {31'd0, rf_we}, 32'd0);
        @(posedge clk); #1;
        set_nop();
    endtask

    // Memory op; ack_at = BUSY cycle index carrying the ack, 0 = never ack (timeout).
    task automatic mem_txn(input logic is_st, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rdat, input int ack_at,
                           input logic [4:0] rd, output int stalls);
        int  busy;
        bit  done;
        @(posedge clk); #1;
        InstF_MW_opcode = is_st ? OPC_STORE : OPC_LOAD;
        InstF_MW_funct3 = f3; AluResultMW = addr; WriteDataMW = wd;
        rdMW = rd; reg_wrMW = 1'b1; wb_selMW = 2'b10;
        stalls = 0; busy = 0; done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (!Stall_MW) begin
                done = 1;
            end else begin
                stalls++;
                if (dbus_req) begin
                    busy++;
                    if (busy == ack_at) begin
                        dbus_ack = 1'b1;
                        dbus_rdata = rdat;
                    end
                end
                @(posedge clk); #1;
                dbus_ack = 1'b0;
                if (ack_at == 0 && busy == TO) begin
                    set_nop();
                    done = 1;
                end
            end
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL mem_txn_bound: transaction at %h never completed, expected completion", addr);
        end
        @(posedge clk); #1;
        set_nop();
    endtask

    initial begin
        int st;
        int busy;
        // Reset state with rst held low.
        set_nop();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dbus_req", {31'd0, dbus_req}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_misalign", {31'd0, misalign_exc}, 32'd0);
        chk("rst_stall", {31'd0, Stall_MW}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Non-memory writeback paths.
        alu_op("alu",  2'b01, 1'b1, 5'd5,  32'h0000_1234, 32'd0, 32'd0, 1'b1, 32'h0000_1234);
        alu_op("pc4",  2'b00, 1'b1, 5'd3,  32'd0, 32'h0000_1000, 32'd0, 1'b1, 32'h0000_1004);
        alu_op("csr",  2'b11, 1'b1, 5'd31, 32'd0, 32'd0, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF);
        alu_op("rd0",  2'b01, 1'b1, 5'd0,  32'h0000_5555, 32'd0, 32'd0, 1'b0, 32'd0);
        alu_op("nowr", 2'b01, 1'b0, 5'd6,  32'h0000_6666, 32'd0, 32'd0, 1'b0, 32'd0);

        // LB, ack on second BUSY cycle.
        push(K_BUS, 32'h0000_0100, 32'd0, 4'b1000, 1'b0);
        push(K_RFW, 32'd10, 32'hFFFF_FF80, 4'd0, 1'b0);
        mem_txn(1'b0, 3'b000, 32'h0000_0103, 32'd0, 32'h80FF_FFFF, 2, 5'd10, st);
        chk("lb_stall", st, 3);

        // SH at offset 2.
        push(K_BUS, 32'h0000_0100, 32'hABCD_ABCD, 4'b1100, 1'b1);
        mem_txn(1'b1, 3'b001, 32'h0000_0102, 32'h0000_ABCD, 32'd0, 1, 5'd4, st);
        chk("sh_stall", st, 2);

        // SB at offset 1, ack on third BUSY cycle.
        push(K_BUS, 32'h0000_0200, 32'h7777_7777, 4'b0010, 1'b1);
        mem_txn(1'b1, 3'b000, 32'h0000_0201, 32'h1234_5677, 32'd0, 3, 5'd4, st);
        chk("sb_stall", st, 4);

        // SW.
        push(K_BUS, 32'h0000_0500, 32'hCAFE_F00D, 4'b1111, 1'b1);
        mem_txn(1'b1, 3'b010, 32'h0000_0500, 32'hCAFE_F00D, 32'd0, 1, 5'd4, st);

        // LHU upper half.
        push(K_BUS, 32'h0000_0300, 32'd0, 4'b1100, 1'b0);
        push(K_RFW, 32'd12, 32'h0000_8001, 4'd0, 1'b0);
        mem_txn(1'b0, 3'b101, 32'h0000_0302, 32'd0, 32'h8001_7FFF, 1, 5'd12, st);

        // LH lower half, sign extended.
        push(K_BUS, 32'h0000_0300, 32'd0, 4'b0011, 1'b0);
        push(K_RFW, 32'd13, 32'hFFFF_9ABC, 4'd0, 1'b0);
        mem_txn(1'b0, 3'b001, 32'h0000_0300, 32'd0, 32'h1234_9ABC, 1, 5'd13, st);

        // LBU byte 1, zero extended.
        push(K_BUS, 32'h0000_0400, 32'd0, 4'b0010, 1'b0);
        push(K_RFW, 32'd11, 32'h0000_00F1, 4'd0, 1'b0);
        mem_txn(1'b0, 3'b100, 32'h0000_0401, 32'd0, 32'h0000_F100, 1, 5'd11, st);

        // funct3 110 behaves as LW.
        push(K_BUS, 32'h0000_0700, 32'd0, 4'b1111, 1'b0);
        push(K_RFW, 32'd15, 32'h0102_0304, 4'd0, 1'b0);
        mem_txn(1'b0, 3'b110, 32'h0000_0700, 32'd0, 32'h0102_0304, 1, 5'd15, st);

        // LW at a misaligned address.
`ifdef LSU_MISALIGN_TRAP_EN
        push(K_MIS, 32'd0, 32'd0, 4'd0, 1'b0);
        mem_txn(1'b0, 3'b010, 32'h0000_0101, 32'd0, 32'h55AA_55AA, 1, 5'd14, st);
        chk("mis_stall", st, 0);
`else
        push(K_BUS, 32'h0000_0100, 32'd0, 4'b1111, 1'b0);
        push(K_RFW, 32'd14, 32'h55AA_55AA, 4'd0, 1'b0);
        mem_txn(1'b0, 3'b010, 32'h0000_0101, 32'd0, 32'h55AA_55AA, 1, 5'd14, st);
        chk("mis_stall", st, 2);
`endif

        // LW with no ack: abort after TO BUSY cycles.
        push(K_BUS, 32'h0000_0600, 32'd0, 4'b1111, 1'b0);
        push(K_BERR, 32'd0, 32'd0, 4'd0, 1'b0);
        mem_txn(1'b0, 3'b010, 32'h0000_0600, 32'd0, 32'd0, 0, 5'd16, st);
        chk("tmo_stall", st, 1 + TO);
        @(negedge clk);
        chk("tmo_idle_stall", {31'd0, Stall_MW}, 32'd0);
        chk("tmo_idle_req", {31'd0, dbus_req}, 32'd0);

        // Reset during BUSY, then a late ack after release.
        @(posedge clk); #1;
        InstF_MW_opcode = OPC_LOAD; InstF_MW_funct3 = 3'b010; AluResultMW = 32'h0000_0800;
        reg_wrMW = 1'b1; rdMW = 5'd9; wb_selMW = 2'b10;
        push(K_BUS, 32'h0000_0800, 32'd0, 4'b1111, 1'b0);
        busy = 0;
        for (int c = 0; c < 20 && busy < 2; c++) begin
            @(negedge clk);
            if (dbus_req) busy++;
        end
        chk("rstb_busy_cycles", busy, 2);
        @(posedge clk); #1;
        rst = 1'b0;
        InstF_MW_opcode = OPC_ALU; wb_selMW = 2'b01; reg_wrMW = 1'b1; rdMW = 5'd7;
        AluResultMW = 32'h0000_0077;
        @(negedge clk);
        chk("rstb_rf_we_low", {31'd0, rf_we}, 32'd0);
        chk("rstb_stall", {31'd0, Stall_MW}, 32'd0);
        @(negedge clk);
        chk("rstb_req_cleared", {31'd0, dbus_req}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        set_nop();
        @(posedge clk); #1;
        dbus_ack = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        chk("late_ack_rf_we", {31'd0, rf_we}, 32'd0);
        chk("late_ack_stall", {31'd0, Stall_MW}, 32'd0);
        @(posedge clk); #1;
        dbus_ack = 1'b0;
        @(negedge clk);
        chk("late_ack_after_rf_we", {31'd0, rf_we}, 32'd0);
        chk("late_ack_after_req", {31'd0, dbus_req}, 32'd0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
